// File: rtl/ada_iaif_pipe.sv
// IA -> IF pipeline boundary: valid/ready on both sides, main entry plus a
// one-deep skid entry so the upstream ready comes straight from a flop.
// Each beat carries a PC, a sideband tag and a misaligned-PC flag.
module ada_iaif_pipe #(
    parameter int          PC_WIDTH   = 32,
    parameter int          TAG_WIDTH  = 4,
    parameter int          ALIGN_BITS = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic [TAG_WIDTH-1:0] in_tag,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_misaligned,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [PC_WIDTH-1:0] RESET_PC_W = PC_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [PC_WIDTH-1:0]  main_pc_q,   main_pc_d;
    logic [TAG_WIDTH-1:0] main_tag_q,  main_tag_d;
    logic                 main_mis_q,  main_mis_d;
    logic [PC_WIDTH-1:0]  skid_pc_q,   skid_pc_d;
    logic [TAG_WIDTH-1:0] skid_tag_q,  skid_tag_d;
    logic                 skid_mis_q,  skid_mis_d;

    logic in_mis;
    logic accept;
    logic drain;

    // Misalignment is judged on the incoming PC and stored with the beat.
    generate
        if (ALIGN_BITS == 0) begin : g_no_align
            assign in_mis = 1'b0;
        end else begin : g_align
            assign in_mis = |in_pc[ALIGN_BITS-1:0];
        end
    endgenerate

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Occupancy next-state and entry updates; flush wins over any handshake.
    always_comb begin
        state_d    = state_q;
        main_pc_d  = main_pc_q;
        main_tag_d = main_tag_q;
        main_mis_d = main_mis_q;
        skid_pc_d  = skid_pc_q;
        skid_tag_d = skid_tag_q;
        skid_mis_d = skid_mis_q;

        if (flush) begin
            // Entries keep their contents so out_* never goes X; only
            // occupancy is dropped.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_pc_d  = in_pc;
                        main_tag_d = in_tag;
                        main_mis_d = in_mis;
                        state_d    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        // Main is still waiting on IF; park the new beat.
                        skid_pc_d  = in_pc;
                        skid_tag_d = in_tag;
                        skid_mis_d = in_mis;
                        state_d    = ST_TWO;
                    end else if (accept && drain) begin
                        main_pc_d  = in_pc;
                        main_tag_d = in_tag;
                        main_mis_d = in_mis;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        main_pc_d  = skid_pc_q;
                        main_tag_d = skid_tag_q;
                        main_mis_d = skid_mis_q;
                        state_d    = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are precomputed so both come straight from flops.
    always_comb begin
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State and storage registers; active-low synchronous reset overrides all.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_pc_q   <= RESET_PC_W;
            main_tag_q  <= '0;
            main_mis_q  <= 1'b0;
            skid_pc_q   <= RESET_PC_W;
            skid_tag_q  <= '0;
            skid_mis_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_pc_q   <= main_pc_d;
            main_tag_q  <= main_tag_d;
            main_mis_q  <= main_mis_d;
            skid_pc_q   <= skid_pc_d;
            skid_tag_q  <= skid_tag_d;
            skid_mis_q  <= skid_mis_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = main_pc_q;
    assign out_tag        = main_tag_q;
    assign out_misaligned = main_mis_q;

endmodule

// File: tb/tb_ada_iaif_pipe.sv
// Directed bench for ada_iaif_pipe: reset, streaming, backpressure, flush,
// misaligned flag and reset while full.
module tb_ada_iaif_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pc;
    logic [3:0]  in_tag;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] out_pc;
    logic [3:0]  out_tag;
    logic        out_misaligned;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ada_iaif_pipe #(
        .PC_WIDTH  (32),
        .TAG_WIDTH (4),
        .ALIGN_BITS(2),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_pc         (in_pc),
        .in_tag        (in_tag),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .out_pc        (out_pc),
        .out_tag       (out_tag),
        .out_misaligned(out_misaligned),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [3:0] tg);
        in_valid = v;
        in_pc    = pc;
        in_tag   = tg;
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] pc, input logic [3:0] tg);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".pc"},    64'(out_pc),    64'(pc));
        check({tag, ".tag"},   64'(out_tag),   64'(tg));
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0);

        // Reset held for two cycles
        tick();
        tick();
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);
        check("rst.out_pc",    64'(out_pc),    64'h0);
        check("rst.out_tag",   64'(out_tag),   64'h0);
        check("rst.mis",       64'(out_misaligned), 64'd0);
        rst = 1'b1;
        tick();
        check("rst.rel_valid", 64'(out_valid), 64'd0);

        // Streaming with IF always ready
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 4'h1);
        tick();
        expect_beat("stream0", 32'h100, 4'h1);
        check("stream0.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h104, 4'h2);
        tick();
        expect_beat("stream1", 32'h104, 4'h2);
        check("stream1.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h108, 4'h3);
        tick();
        expect_beat("stream2", 32'h108, 4'h3);
        check("stream2.in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 32'h0, 4'h0);
        tick();
        check("stream.drained", 64'(out_valid), 64'd0);

        // Backpressure fills main and skid
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 4'h5);
        tick();
        expect_beat("bp.one", 32'h200, 4'h5);
        check("bp.one.in_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h204, 4'h6);
        tick();
        check("bp.two.in_ready", 64'(in_ready), 64'd0);
        expect_beat("bp.two", 32'h200, 4'h5);
        drive(1'b1, 32'h208, 4'h7);
        tick();
        check("bp.hold.in_ready", 64'(in_ready), 64'd0);
        expect_beat("bp.hold", 32'h200, 4'h5);
        out_ready = 1'b1;
        tick();
        expect_beat("bp.out1", 32'h204, 4'h6);
        check("bp.out1.in_ready", 64'(in_ready), 64'd1);
        tick();
        expect_beat("bp.out2", 32'h208, 4'h7);
        drive(1'b0, 32'h0, 4'h0);
        tick();
        check("bp.empty", 64'(out_valid), 64'd0);

        // Flush while full, with a beat offered the same cycle
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 4'h8);
        tick();
        drive(1'b1, 32'h304, 4'h9);
        tick();
        check("fl.full.in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h308, 4'hB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0);
        check("fl.out_valid", 64'(out_valid), 64'd0);
        check("fl.in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("fl.after%0d.valid", i), 64'(out_valid), 64'd0);
        end

        // Misaligned flag travels with the beat
        drive(1'b1, 32'h402, 4'hA);
        tick();
        expect_beat("mis.402", 32'h402, 4'hA);
        check("mis.402.flag", 64'(out_misaligned), 64'd1);
        drive(1'b1, 32'h404, 4'h3);
        tick();
        expect_beat("mis.404", 32'h404, 4'h3);
        check("mis.404.flag", 64'(out_misaligned), 64'd0);
        drive(1'b0, 32'h0, 4'h0);
        tick();
        check("mis.empty", 64'(out_valid), 64'd0);

        // Reset while full overrides handshakes
        out_ready = 1'b0;
        drive(1'b1, 32'h500, 4'hC);
        tick();
        drive(1'b1, 32'h504, 4'hD);
        tick();
        check("mrst.full.in_ready", 64'(in_ready), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h508, 4'hE);
        tick();
        rst = 1'b1;
        drive(1'b0, 32'h0, 4'h0);
        check("mrst.out_valid", 64'(out_valid), 64'd0);
        check("mrst.in_ready",  64'(in_ready),  64'd1);
        check("mrst.out_pc",    64'(out_pc),    64'h0);
        check("mrst.out_tag",   64'(out_tag),   64'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("mrst.after%0d.valid", i), 64'(out_valid), 64'd0);
        end

        // Pipe works again after the mid-run reset
        drive(1'b1, 32'h600, 4'h4);
        tick();
        expect_beat("resume", 32'h600, 4'h4);
        drive(1'b0, 32'h0, 4'h0);
        tick();
        check("resume.empty", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ada_iaif_pipe.md
Name: ada_iaif_pipe

Overview:
- Parametrised Instruction-Address to Instruction-Fetch pipeline boundary. Next generation of the plain IA/IF PC register.
- Replaces the stall-hold register with a valid/ready handshake on both sides and a 2-entry skid buffer, so the upstream ready is registered and no stall path is combinational.
- Also provides a flush, a per-beat tag, and a misaligned-PC exception flag.
- Sits between the PC-select logic (IA) and the instruction-memory request logic (IF).

Parameters:
- PC_WIDTH, 32, width of the PC path.
- TAG_WIDTH, 4, width of the sideband tag carried with each PC (e.g. branch-prediction info). Must be >= 1.
- ALIGN_BITS, 2, number of PC LSBs that must be zero for an aligned fetch. 0 disables the check.
- RESET_PC, 32'h0000_0000, value driven on out_pc while reset is asserted and after reset. Truncated to PC_WIDTH.

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 resets on the next rising clk edge).
- in_pc  in  PC_WIDTH  new PC from IA.
- in_tag  in  TAG_WIDTH  sideband travelling with in_pc.
- in_valid  in  1  IA presents a beat.
- in_ready  out  1  block can accept a beat. Registered.
- flush  in  1  discard all held beats and any incoming beat this cycle.
- out_pc  out  PC_WIDTH  PC to IF.
- out_tag  out  TAG_WIDTH  tag to IF.
- out_misaligned  out  1  out_pc has a nonzero bit in [ALIGN_BITS-1:0].
- out_valid  out  1  out_* fields hold a beat.
- out_ready  in  1  IF accepts the beat.

Behaviour:
- Transfer rule: a beat transfers upstream when in_valid & in_ready, and downstream when out_valid & out_ready, both at the rising clk edge.
- Storage: main entry (drives out_*) plus skid entry. Occupancy state machine:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - TWO: out_valid=1, in_ready=0.
- Transitions (no flush):
  - EMPTY + accept -> ONE. Beat appears on out_* the next cycle (1-cycle latency).
  - ONE + accept + no drain -> TWO. Incoming beat goes to skid.
  - ONE + drain + no accept -> EMPTY.
  - ONE + accept + drain -> ONE. Incoming beat goes to main.
  - TWO + drain -> ONE. Skid moves to main.
  - Any other combination holds the current state.
- Ordering: strict FIFO order. No beat is ever duplicated or dropped except by flush.
- Outputs while no drain: when out_valid=1 and out_ready=0, out_pc, out_tag and out_misaligned are stable.
- Outputs when empty: out_pc/out_tag hold their last value. Content is don't-care for IF, but must not be X after reset.
- in_ready is a function of registered state only (in_ready = state != TWO). No combinational path from out_ready to in_ready.
- Misaligned flag:
  - Computed from in_pc at capture and stored with the beat.
  - ALIGN_BITS=0 -> always 0.
  - The beat still passes; only the flag is raised.
- Flush:
  - Takes priority over everything in the same cycle. Next state is EMPTY; any in_valid beat that cycle is discarded; the out_valid/out_ready transfer that cycle still counts as delivered to IF.
  - in_ready is 1 the cycle after flush.
- Reset (rst=0 at the clk edge):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_pc=RESET_PC, out_tag=0, out_misaligned=0.
  - Skid contents are cleared to the same values.
  - Reset during any state, including TWO, overrides flush and handshakes.
- Arithmetic: none on the PC. Values pass bit-exact at PC_WIDTH.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release -> out_valid=0, in_ready=1, out_pc=32'h0000_0000, out_tag=0.
- Stream: in_valid=1 with PCs 0x100, 0x104, 0x108 on consecutive cycles, out_ready=1 throughout -> out_pc shows 0x100, 0x104, 0x108 on cycles +1, +2, +3; in_ready stays 1.
- Backpressure: out_ready=0, push 0x200 then 0x204 -> TWO, in_ready=0; 0x208 is held by IA. Raise out_ready -> outputs 0x200, 0x204, 0x208 in order with no gap and no loss.
- Flush in TWO: with 0x300 and 0x304 held and in_valid=1 carrying 0x308, assert flush -> next cycle out_valid=0, in_ready=1; none of 0x300, 0x304, 0x308 appear afterwards.
- Misaligned: ALIGN_BITS=2, push 0x402 with tag 4'hA -> out_pc=0x402, out_tag=4'hA, out_misaligned=1. Push 0x404 -> out_misaligned=0.
- Reset mid-operation: in TWO, drive rst=0 for one cycle -> next cycle out_valid=0, out_pc=RESET_PC, in_ready=1; held beats are gone.
